// File: rtl/fetch_stage_if.sv
// Instruction-memory handshake bundle between the fetch stage and imem.
//   imem_addr  : fetch address (master -> slave)
//   imem_req   : fetch request (master -> slave)
//   imem_rdata : fetched instruction (slave -> master)
//   imem_valid : imem_rdata valid this cycle (slave -> master)
interface fetch_stage_if #(
    parameter int W = 32
);
    logic [W-1:0] imem_addr;
    logic         imem_req;
    logic [W-1:0] imem_rdata;
    logic         imem_valid;

    modport master (output imem_addr, output imem_req,
                    input  imem_rdata, input imem_valid);
    modport slave  (input  imem_addr, input imem_req,
                    output imem_rdata, output imem_valid);
endinterface

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage with IF/ID pipeline register.
// Holds the PC, fetches over a variable-latency imem handshake, absorbs
// hazard stalls in a one-entry hold buffer and handles branch/jump redirects.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   stall               : hazard unit, hold IF/ID
//   branch_taken/target : EX-stage branch redirect (higher priority)
//   jump/jump_target    : ID-stage jump redirect
//   imem                : instruction-memory handshake (master side)
//   if_id_instr/pc4/valid, opcode : IF/ID contents to decode/control
module fetch_stage #(
    parameter int                 INSTR_W  = 32,
    parameter logic [INSTR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic [INSTR_W-1:0] branch_target,
    input  logic               jump,
    input  logic [INSTR_W-1:0] jump_target,
    fetch_stage_if.master      imem,
    output logic [INSTR_W-1:0] if_id_instr,
    output logic [INSTR_W-1:0] if_id_pc4,
    output logic               if_id_valid,
    output logic [5:0]         opcode
);
    typedef enum logic [1:0] {FETCH, HOLD, DRAIN} state_t;

    localparam logic [INSTR_W-1:0] FOUR = INSTR_W'(4);

    state_t             state_q;
    logic [INSTR_W-1:0] pc_q;
    logic [INSTR_W-1:0] drain_addr_q;   // address of the abandoned request
    logic [INSTR_W-1:0] instr_q, pc4_q;
    logic               valid_q;
    logic [INSTR_W-1:0] buf_instr_q, buf_pc4_q;

    logic               redirect;
    logic [INSTR_W-1:0] target;
    logic [INSTR_W-1:0] pc_plus4;

    // Branch is resolved in EX, i.e. it belongs to the older instruction.
    assign redirect = branch_taken | jump;
    assign target   = branch_taken ? branch_target : jump_target;
    assign pc_plus4 = pc_q + FOUR;

    // During DRAIN pc_q already holds the redirect target, but the
    // outstanding request must keep its original address until it completes.
    assign imem.imem_req  = !reset && (state_q != HOLD);
    assign imem.imem_addr = (state_q == DRAIN) ? drain_addr_q : pc_q;

    assign if_id_instr = instr_q;
    assign if_id_pc4   = pc4_q;
    assign if_id_valid = valid_q;
    assign opcode      = instr_q[INSTR_W-1:INSTR_W-6];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= FETCH;
            pc_q         <= RESET_PC;
            drain_addr_q <= '0;
            instr_q      <= '0;
            pc4_q        <= '0;
            valid_q      <= 1'b0;
            buf_instr_q  <= '0;
            buf_pc4_q    <= '0;
        end else begin
            case (state_q)
                FETCH: begin
                    if (redirect) begin
                        instr_q <= '0;
                        pc4_q   <= '0;
                        valid_q <= 1'b0;
                        pc_q    <= target;
                        // Request still in flight: wait it out before refetching.
                        if (!imem.imem_valid) begin
                            drain_addr_q <= pc_q;
                            state_q      <= DRAIN;
                        end
                    end else if (imem.imem_valid) begin
                        pc_q <= pc_plus4;
                        if (!stall) begin
                            instr_q <= imem.imem_rdata;
                            pc4_q   <= pc_plus4;
                            valid_q <= 1'b1;
                        end else begin
                            buf_instr_q <= imem.imem_rdata;
                            buf_pc4_q   <= pc_plus4;
                            state_q     <= HOLD;
                        end
                    end else if (!stall) begin
                        instr_q <= '0;
                        valid_q <= 1'b0;
                    end
                end
                HOLD: begin
                    if (redirect) begin
                        instr_q <= '0;
                        pc4_q   <= '0;
                        valid_q <= 1'b0;
                        pc_q    <= target;
                        state_q <= FETCH;
                    end else if (!stall) begin
                        instr_q <= buf_instr_q;
                        pc4_q   <= buf_pc4_q;
                        valid_q <= 1'b1;
                        state_q <= FETCH;
                    end
                end
                DRAIN: begin
                    // Youngest redirect wins; the drained data is dropped.
                    if (redirect) pc_q <= target;
                    if (imem.imem_valid) state_q <= FETCH;
                    instr_q <= '0;
                    pc4_q   <= '0;
                    valid_q <= 1'b0;
                end
                default: state_q <= FETCH;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
    logic        clk = 1'b0;
    logic        reset, stall, branch_taken, jump;
    logic [31:0] branch_target, jump_target;
    logic [31:0] if_id_instr, if_id_pc4;
    logic        if_id_valid;
    logic [5:0]  opcode;

    // second instance checks PC wrap with RESET_PC = FFFF_FFFC
    logic        z;
    logic [31:0] z32;
    logic [31:0] instr2, pc42;
    logic        valid2;
    logic [5:0]  opcode2;

    int checks = 0;
    int errors = 0;

    fetch_stage_if #(.W(32)) m  ();
    fetch_stage_if #(.W(32)) m2 ();

    fetch_stage #(.INSTR_W(32), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .reset(reset), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .jump_target(jump_target), .imem(m),
        .if_id_instr(if_id_instr), .if_id_pc4(if_id_pc4),
        .if_id_valid(if_id_valid), .opcode(opcode));

    fetch_stage #(.INSTR_W(32), .RESET_PC(32'hFFFF_FFFC)) dut2 (
        .clk(clk), .reset(reset), .stall(z),
        .branch_taken(z), .branch_target(z32),
        .jump(z), .jump_target(z32), .imem(m2),
        .if_id_instr(instr2), .if_id_pc4(pc42),
        .if_id_valid(valid2), .opcode(opcode2));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        stall, br;
        logic [31:0] bt;
        logic        jmp;
        logic [31:0] jt, rd;
        logic        vld;
        logic        req;
        logic [31:0] addr, instr, pc4;
        logic        ivld;
    } vec_t;

    function automatic vec_t mk(logic s, logic b, logic [31:0] bt, logic j, logic [31:0] jt,
                                logic [31:0] rd, logic v, logic req, logic [31:0] addr,
                                logic [31:0] instr, logic [31:0] pc4, logic iv);
        vec_t r;
        r.stall = s; r.br = b; r.bt = bt; r.jmp = j; r.jt = jt; r.rd = rd; r.vld = v;
        r.req = req; r.addr = addr; r.instr = instr; r.pc4 = pc4; r.ivld = iv;
        return r;
    endfunction

    vec_t vq[$];

    initial begin
        z = 1'b0; z32 = '0;
        reset = 1'b1; stall = 0; branch_taken = 0; jump = 0;
        branch_target = '0; jump_target = '0;
        m.imem_rdata = '0;  m.imem_valid = 0;
        m2.imem_rdata = '0; m2.imem_valid = 0;

        //            stall br bt           jmp jt           rdata         vld req addr          instr         pc4           ivld
        // zero-wait stream
        vq.push_back(mk(0,0,0,          0,0,          32'h8C010004,1, 1,32'h00000000,32'h8C010004,32'h00000004,1));
        vq.push_back(mk(0,0,0,          0,0,          32'hAC020008,1, 1,32'h00000004,32'hAC020008,32'h00000008,1));
        vq.push_back(mk(0,0,0,          0,0,          32'h10220003,1, 1,32'h00000008,32'h10220003,32'h0000000C,1));
        vq.push_back(mk(0,0,0,          0,0,          32'h01000020,1, 1,32'h0000000C,32'h01000020,32'h00000010,1));
        // stall 3 cycles with capture at 0x10
        vq.push_back(mk(1,0,0,          0,0,          32'h8D2A0000,1, 1,32'h00000010,32'h01000020,32'h00000010,1));
        vq.push_back(mk(1,0,0,          0,0,          32'h0,       0, 0,32'h00000014,32'h01000020,32'h00000010,1));
        vq.push_back(mk(1,0,0,          0,0,          32'h0,       0, 0,32'h00000014,32'h01000020,32'h00000010,1));
        vq.push_back(mk(0,0,0,          0,0,          32'h0,       0, 0,32'h00000014,32'h8D2A0000,32'h00000014,1));
        // 3-cycle latency at 0x14
        vq.push_back(mk(0,0,0,          0,0,          32'h0,       0, 1,32'h00000014,32'h0,       32'h00000014,0));
        vq.push_back(mk(0,0,0,          0,0,          32'h0,       0, 1,32'h00000014,32'h0,       32'h00000014,0));
        vq.push_back(mk(0,0,0,          0,0,          32'h3C01ABCD,1, 1,32'h00000014,32'h3C01ABCD,32'h00000018,1));
        vq.push_back(mk(0,0,0,          0,0,          32'h24420001,1, 1,32'h00000018,32'h24420001,32'h0000001C,1));
        vq.push_back(mk(0,0,0,          0,0,          32'h00431020,1, 1,32'h0000001C,32'h00431020,32'h00000020,1));
        // request to 0x20, branch to 0x40 before data -> DRAIN
        vq.push_back(mk(0,0,0,          0,0,          32'h0,       0, 1,32'h00000020,32'h0,       32'h00000020,0));
        vq.push_back(mk(0,1,32'h40,     0,0,          32'h0,       0, 1,32'h00000020,32'h0,       32'h0,       0));
        vq.push_back(mk(0,0,0,          0,0,          32'hDEADBEEF,1, 1,32'h00000020,32'h0,       32'h0,       0));
        vq.push_back(mk(0,0,0,          0,0,          32'h08000000,1, 1,32'h00000040,32'h08000000,32'h00000044,1));
        // jump into DRAIN, then a newer jump overwrites the target
        vq.push_back(mk(0,0,0,          1,32'h80,     32'h0,       0, 1,32'h00000044,32'h0,       32'h0,       0));
        vq.push_back(mk(0,0,0,          1,32'h90,     32'h0,       0, 1,32'h00000044,32'h0,       32'h0,       0));
        vq.push_back(mk(0,0,0,          0,0,          32'hCAFEF00D,1, 1,32'h00000044,32'h0,       32'h0,       0));
        vq.push_back(mk(0,0,0,          0,0,          32'h11111111,1, 1,32'h00000090,32'h11111111,32'h00000094,1));
        // HOLD, then branch+jump+stall together: branch wins, IF/ID cleared
        vq.push_back(mk(1,0,0,          0,0,          32'h22222222,1, 1,32'h00000094,32'h11111111,32'h00000094,1));
        vq.push_back(mk(1,1,32'h100,    1,32'h200,    32'h0,       0, 0,32'h00000098,32'h0,       32'h0,       0));
        vq.push_back(mk(0,0,0,          0,0,          32'h33333333,1, 1,32'h00000100,32'h33333333,32'h00000104,1));
        // redirect coinciding with valid data: discard, stay FETCH
        vq.push_back(mk(0,1,32'h200,    0,0,          32'h44444444,1, 1,32'h00000104,32'h0,       32'h0,       0));
        vq.push_back(mk(0,0,0,          0,0,          32'h0,       0, 1,32'h00000200,32'h0,       32'h0,       0));

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_instr", if_id_instr, 32'h0);
        chk("rst_pc4",   if_id_pc4,   32'h0);
        chk("rst_valid", {31'h0, if_id_valid}, 32'h0);
        chk("rst_opcode", {26'h0, opcode}, 32'h0);
        chk("rst_req",   {31'h0, m.imem_req}, 32'h0);

        // wrap-around fetch on the second instance
        @(negedge clk);
        reset = 1'b0;
        m2.imem_valid = 1'b1; m2.imem_rdata = 32'h8C010004;
        #1;
        chk("wrap_req",  {31'h0, m2.imem_req}, 32'h1);
        chk("wrap_addr", m2.imem_addr, 32'hFFFF_FFFC);
        chk("first_addr", m.imem_addr, 32'h0);
        @(posedge clk); #1;
        chk("wrap_pc4",   pc42, 32'h0);
        chk("wrap_valid", {31'h0, valid2}, 32'h1);
        chk("wrap_opcode", {26'h0, opcode2}, 32'h23);
        @(negedge clk);
        m2.imem_valid = 1'b0;
        #1;
        chk("wrap_next_addr", m2.imem_addr, 32'h0);

        // table
        foreach (vq[i]) begin
            stall = vq[i].stall; branch_taken = vq[i].br; branch_target = vq[i].bt;
            jump = vq[i].jmp; jump_target = vq[i].jt;
            m.imem_rdata = vq[i].rd; m.imem_valid = vq[i].vld;
            #1;
            chk($sformatf("v%0d_req", i),  {31'h0, m.imem_req}, {31'h0, vq[i].req});
            chk($sformatf("v%0d_addr", i), m.imem_addr, vq[i].addr);
            @(posedge clk); #1;
            chk($sformatf("v%0d_instr", i), if_id_instr, vq[i].instr);
            chk($sformatf("v%0d_pc4", i),   if_id_pc4,   vq[i].pc4);
            chk($sformatf("v%0d_valid", i), {31'h0, if_id_valid}, {31'h0, vq[i].ivld});
            chk($sformatf("v%0d_opcode", i), {26'h0, opcode}, {26'h0, vq[i].instr[31:26]});
            @(negedge clk);
        end

        // reset while in DRAIN
        jump = 1'b1; jump_target = 32'h300; m.imem_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        jump = 1'b0;
        #1;
        chk("drain_addr", m.imem_addr, 32'h200);
        chk("drain_req",  {31'h0, m.imem_req}, 32'h1);
        reset = 1'b1;
        #1;
        chk("rst_in_drain_req", {31'h0, m.imem_req}, 32'h0);
        @(posedge clk); #1;
        chk("rst2_instr", if_id_instr, 32'h0);
        chk("rst2_pc4",   if_id_pc4,   32'h0);
        chk("rst2_valid", {31'h0, if_id_valid}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst2_addr", m.imem_addr, 32'h0);
        chk("rst2_req",  {31'h0, m.imem_req}, 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
